// File: rtl/fifo_ctrl_pkg.sv
// Shared definitions for the FIFO write-side control logic.
// Holds only the arbiter state encoding.
package fifo_ctrl_pkg;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_LOCK = 1'b1
    } arb_state_e;

endpackage

// File: rtl/rr_priority_picker.sv
// Round-robin picker: rotates the request mask so rr_ptr sits at bit 0,
// priority-encodes the lowest set bit, then maps it back to a requester index.
module rr_priority_picker #(
    parameter int NUM_REQ = 3,
    localparam int IDX_W  = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_mask_i,
    input  logic [IDX_W-1:0]   rr_ptr_i,
    output logic               found_o,
    output logic [IDX_W-1:0]   index_o
);

    logic [NUM_REQ-1:0] rotated;
    logic [IDX_W-1:0]   src_idx;

    always_comb begin
        rotated = '0;
        src_idx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            src_idx    = IDX_W'((int'(rr_ptr_i) + k) % NUM_REQ);
            rotated[k] = req_mask_i[src_idx];
        end
    end

    // Walk from the highest rotated slot down so the lowest hit wins.
    always_comb begin
        found_o = |rotated;
        index_o = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (rotated[k]) begin
                index_o = IDX_W'((int'(rr_ptr_i) + k) % NUM_REQ);
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Packet-locked round-robin arbiter sharing the async FIFO write port among
// NUM_REQ requesters; a grant is held until the owner's last word is written.
module fifo_wr_arbiter
    import fifo_ctrl_pkg::*;
#(
    parameter int NUM_REQ    = 3,
    parameter int DATA_WIDTH = 8,
    localparam int GRANT_W   = $clog2(NUM_REQ)
) (
    input  logic                          wclk_i,
    input  logic                          wrst_i,
    input  logic [NUM_REQ-1:0]            req_en_i,
    input  logic [NUM_REQ-1:0]            req_valid_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
    input  logic [NUM_REQ-1:0]            req_last_i,
    output logic [NUM_REQ-1:0]            req_ready_o,
    input  logic                          wfull_i,
    output logic                          winc_o,
    output logic [DATA_WIDTH-1:0]         wdata_o,
    output logic [GRANT_W-1:0]            grant_id_o,
    output logic                          busy_o
);

    arb_state_e                           state_q, state_d;
    logic [GRANT_W-1:0]                   grant_id_q, grant_id_d;
    logic [GRANT_W-1:0]                   rr_ptr_q, rr_ptr_d;

    logic [NUM_REQ-1:0][DATA_WIDTH-1:0]   data_arr;
    logic [DATA_WIDTH-1:0]                own_data;
    logic                                 own_valid;
    logic                                 own_last;
    logic                                 accept;
    logic                                 pick_found;
    logic [GRANT_W-1:0]                   pick_idx;

    assign data_arr  = req_data_i;
    assign own_data  = data_arr[grant_id_q];
    assign own_valid = req_valid_i[grant_id_q];
    assign own_last  = req_last_i[grant_id_q];
    assign accept    = (state_q == ARB_LOCK) && own_valid && !wfull_i;

    rr_priority_picker #(
        .NUM_REQ (NUM_REQ)
    ) u_picker (
        .req_mask_i (req_valid_i & req_en_i),
        .rr_ptr_i   (rr_ptr_q),
        .found_o    (pick_found),
        .index_o    (pick_idx)
    );

    always_ff @(posedge wclk_i) begin
        if (wrst_i) begin
            state_q    <= ARB_IDLE;
            grant_id_q <= '0;
            rr_ptr_q   <= '0;
        end else begin
            state_q    <= state_d;
            grant_id_q <= grant_id_d;
            rr_ptr_q   <= rr_ptr_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        grant_id_d = grant_id_q;
        rr_ptr_d   = rr_ptr_q;
        unique case (state_q)
            ARB_IDLE: begin
                if (pick_found) begin
                    grant_id_d = pick_idx;
                    state_d    = ARB_LOCK;
                end
            end
            ARB_LOCK: begin
                // Only a written last word releases the grant; req_en is ignored here.
                if (accept && own_last) begin
                    state_d  = ARB_IDLE;
                    rr_ptr_d = (grant_id_q == GRANT_W'(NUM_REQ - 1)) ? '0
                                                                     : grant_id_q + 1'b1;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_comb begin
        winc_o      = 1'b0;
        req_ready_o = '0;
        wdata_o     = '0;
        if (state_q == ARB_LOCK) begin
            wdata_o                 = own_data;
            winc_o                  = accept;
            req_ready_o[grant_id_q] = accept;
        end
    end

    assign busy_o     = (state_q == ARB_LOCK);
    assign grant_id_o = grant_id_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Randomised and directed bench for fifo_wr_arbiter against a queue-based
// requester model and a cycle-level arbitration reference.
module tb_fifo_wr_arbiter;

    localparam int N  = 3;
    localparam int DW = 8;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   req_en = '1;
    logic [N-1:0]   req_valid = '0;
    logic [N*DW-1:0] req_data = '0;
    logic [N-1:0]   req_last = '0;
    logic [N-1:0]   req_ready;
    logic           wfull = 1'b0;
    logic           winc;
    logic [DW-1:0]  wdata;
    logic [1:0]     grant_id;
    logic           busy;

    fifo_wr_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW)) dut (
        .wclk_i      (clk),
        .wrst_i      (rst),
        .req_en_i    (req_en),
        .req_valid_i (req_valid),
        .req_data_i  (req_data),
        .req_last_i  (req_last),
        .req_ready_o (req_ready),
        .wfull_i     (wfull),
        .winc_o      (winc),
        .wdata_o     (wdata),
        .grant_id_o  (grant_id),
        .busy_o      (busy)
    );

    always #5 clk = ~clk;

    int npass = 0;
    int ntot  = 0;
    int cyc   = 0;
    bit chk_en = 1'b0;
    bit rnd_gate = 1'b0;

    // Requester word queues: {last, data}
    logic [8:0] pq [0:N-1][$];
    logic [N-1:0] acc_prev = '0;

    // Observed writes
    int          log_own[$];
    logic [7:0]  log_dat[$];
    int          log_cyc[$];
    int          exp_o[$];
    logic [7:0]  exp_d[$];
    int          exp_g[$];

    // Reference model state
    bit  m_busy  = 1'b0;
    int  m_owner = 0;
    int  m_ptr   = 0;
    bit  e_winc;
    logic [N-1:0] e_ready;
    logic [7:0]   e_data;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        ntot++;
        if (act === expv) npass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, expv, cyc);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Requester behaviour: present queue head, pop it once it was accepted.
    always @(posedge clk) begin
        #1;
        for (int i = 0; i < N; i++) begin
            if (acc_prev[i] && pq[i].size() > 0) void'(pq[i].pop_front());
            if (pq[i].size() > 0) begin
                req_valid[i]      = rnd_gate ? ($urandom_range(0, 3) != 0) : 1'b1;
                req_data[i*DW +: DW] = pq[i][0][7:0];
                req_last[i]       = pq[i][0][8];
            end else begin
                req_valid[i]      = 1'b0;
                req_data[i*DW +: DW] = 8'h00;
                req_last[i]       = 1'b0;
            end
        end
    end

    // Per-cycle compare against the reference, then advance the reference.
    always @(negedge clk) begin
        e_winc  = m_busy && req_valid[m_owner] && !wfull;
        e_ready = e_winc ? N'(1 << m_owner) : '0;
        e_data  = m_busy ? req_data[m_owner*DW +: DW] : 8'h00;
        acc_prev = req_ready;
        if (winc === 1'b1) begin
            log_own.push_back(int'(grant_id));
            log_dat.push_back(wdata);
            log_cyc.push_back(cyc);
        end
        if (chk_en) begin
            chk("busy", {31'd0, busy}, {31'd0, m_busy});
            chk("winc", {31'd0, winc}, {31'd0, e_winc});
            chk("req_ready", {29'd0, req_ready}, {29'd0, e_ready});
            chk("wdata", {24'd0, wdata}, {24'd0, e_data});
            if (m_busy) chk("grant_id", {30'd0, grant_id}, m_owner);
        end
        if (rst) begin
            m_busy = 1'b0; m_owner = 0; m_ptr = 0;
        end else if (!m_busy) begin
            for (int k = 0; k < N; k++) begin
                if (!m_busy && req_valid[(m_ptr + k) % N] && req_en[(m_ptr + k) % N]) begin
                    m_owner = (m_ptr + k) % N;
                    m_busy  = 1'b1;
                end
            end
        end else if (e_winc && req_last[m_owner]) begin
            m_busy = 1'b0;
            m_ptr  = (m_owner + 1) % N;
        end
        cyc++;
    end

    task automatic do_reset(input logic [N-1:0] en);
        rst = 1'b1; wfull = 1'b0; req_en = en;
        tick();
        for (int i = 0; i < N; i++) pq[i].delete();
        tick();
        rst = 1'b0;
        log_own.delete(); log_dat.delete(); log_cyc.delete();
    endtask

    task automatic wait_log(input int n, input int budget);
        int b;
        b = 0;
        while (log_own.size() < n && b < budget) begin
            tick();
            b++;
        end
        chk("wait_writes", log_own.size() >= n, 1);
    endtask

    task automatic cmp_log(input string nm);
        chk({nm, "_count"}, log_own.size() >= exp_o.size(), 1);
        for (int k = 0; k < exp_o.size(); k++) begin
            if (k < log_own.size()) begin
                chk({nm, "_owner"}, log_own[k], exp_o[k]);
                chk({nm, "_data"}, {24'd0, log_dat[k]}, {24'd0, exp_d[k]});
                if (k > 0) chk({nm, "_gap"}, log_cyc[k] - log_cyc[k-1], exp_g[k-1]);
            end
        end
    endtask

    initial begin
        // Reset held two cycles with every requester valid
        for (int i = 0; i < N; i++) pq[i].push_back({1'b1, 8'hEE});
        tick();
        chk_en = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk("rst_winc", {31'd0, winc}, 0);
            chk("rst_busy", {31'd0, busy}, 0);
            chk("rst_ready", {29'd0, req_ready}, 0);
            chk("rst_grant", {30'd0, grant_id}, 0);
            tick();
        end

        // Round robin over single-word packets
        do_reset(3'b111);
        for (int k = 0; k < 8; k++) begin
            pq[0].push_back({1'b1, 8'hA0});
            pq[1].push_back({1'b1, 8'hB1});
            pq[2].push_back({1'b1, 8'hC2});
        end
        wait_log(4, 20);
        exp_o = '{0, 1, 2, 0}; exp_d = '{8'hA0, 8'hB1, 8'hC2, 8'hA0}; exp_g = '{2, 2, 2};
        cmp_log("rr");

        // Packet lock: 4-word packet from req0 while req1 waits
        do_reset(3'b111);
        pq[0] = '{{1'b0, 8'h10}, {1'b0, 8'h11}, {1'b0, 8'h12}, {1'b1, 8'h13}};
        pq[1] = '{{1'b1, 8'h20}};
        wait_log(5, 20);
        exp_o = '{0, 0, 0, 0, 1}; exp_d = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h20};
        exp_g = '{1, 1, 1, 2};
        cmp_log("lock");

        // Backpressure: wfull for 3 cycles after two words
        do_reset(3'b111);
        pq[0] = '{{1'b0, 8'h30}, {1'b0, 8'h31}, {1'b0, 8'h32}, {1'b1, 8'h33}};
        wait_log(2, 20);
        wfull = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("bp_winc", {31'd0, winc}, 0);
            chk("bp_ready", {29'd0, req_ready}, 0);
            chk("bp_busy", {31'd0, busy}, 1);
            chk("bp_grant", {30'd0, grant_id}, 0);
            tick();
        end
        wfull = 1'b0;
        wait_log(4, 20);
        exp_o = '{0, 0, 0, 0}; exp_d = '{8'h30, 8'h31, 8'h32, 8'h33}; exp_g = '{1, 4, 1};
        cmp_log("bp");

        // Enable mask skips requester 1
        do_reset(3'b101);
        for (int k = 0; k < 6; k++) begin
            pq[0].push_back({1'b1, 8'(8'h40 + k)});
            pq[1].push_back({1'b1, 8'h55});
            pq[2].push_back({1'b1, 8'(8'h60 + k)});
        end
        wait_log(4, 30);
        exp_o = '{0, 2, 0, 2}; exp_d = '{8'h40, 8'h60, 8'h41, 8'h61}; exp_g = '{2, 2, 2};
        cmp_log("mask");

        // Reset during the second word of a 4-word packet
        do_reset(3'b111);
        pq[1] = '{{1'b1, 8'h50}};
        pq[2] = '{{1'b0, 8'h70}, {1'b0, 8'h71}, {1'b0, 8'h72}, {1'b1, 8'h73}};
        wait_log(2, 20);
        rst = 1'b1;
        pq[0].push_back({1'b1, 8'h80});
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("rstmid_busy", {31'd0, busy}, 0);
        wait_log(4, 20);
        exp_o = '{1, 2, 2, 0}; exp_d = '{8'h50, 8'h70, 8'h71, 8'h80}; exp_g = '{2, 1, 2};
        cmp_log("rstmid");

        // Random traffic, backpressure, mask changes and occasional resets
        do_reset(3'b111);
        rnd_gate = 1'b1;
        for (int c = 0; c < 2500; c++) begin
            wfull = ($urandom_range(0, 3) == 0);
            rst   = ($urandom_range(0, 199) == 0);
            if (c % 50 == 0) req_en = N'($urandom_range(0, 7));
            for (int i = 0; i < N; i++) begin
                if (pq[i].size() < 2) begin
                    int len;
                    len = $urandom_range(1, 4);
                    for (int j = 0; j < len; j++) pq[i].push_back({j == len - 1, 8'($urandom)});
                end
            end
            tick();
        end
        rst = 1'b0;
        tick();
        chk_en = 1'b0;

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
